// File: rtl/jtkcpu_busresp.sv
// CPU-to-memory bus responder: serves each CPU access once from the backend and answers repeats from a latch.
// Optional request timeout when JTKCPU_BUSRESP_TIMEOUT_EN is defined.
module jtkcpu_busresp #(
  parameter int unsigned WS   = 0,
  parameter int unsigned TOUT = 255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen2,
  input  logic [23:0] addr,
  input  logic [7:0]  cpu_dout,
  input  logic        we,
  output logic [7:0]  cpu_din,
  output logic        dtack,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ok,
  input  logic [7:0]  mem_dout,
  output logic        err
);

  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 8;
  localparam int unsigned WSW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WS, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   tag_addr_q, tag_addr_d;
  logic            tag_we_q, tag_we_d;
  logic [DW-1:0]   tag_dout_q, tag_dout_d;
  logic            valid_q, valid_d;
  logic            ok_q, ok_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_req_q, mem_req_d;
  logic [DW-1:0]   cpu_din_q, cpu_din_d;
  logic [WSW-1:0]  ws_cnt_q, ws_cnt_d;
  logic            mismatch_c;

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
  localparam int unsigned TW = 16;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            err_q, err_d;
  assign err = err_q;
`else
  logic            unused_tout;
  assign unused_tout = (TOUT != 0);
  assign err = 1'b0;
`endif

  // The live CPU access differs from the one last served
  assign mismatch_c = !valid_q || (addr != tag_addr_q) || (we != tag_we_q) ||
                      (cpu_dout != tag_dout_q);
  assign dtack      = ok_q & ~mismatch_c;

  assign cpu_din  = cpu_din_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign mem_req  = mem_req_q;

  always_comb begin
    state_d    = state_q;
    tag_addr_d = tag_addr_q;
    tag_we_d   = tag_we_q;
    tag_dout_d = tag_dout_q;
    valid_d    = valid_q;
    ok_d       = ok_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;
    mem_req_d  = mem_req_q;
    cpu_din_d  = cpu_din_q;
    ws_cnt_d   = ws_cnt_q;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mismatch_c) begin
          tag_addr_d = addr;
          tag_we_d   = we;
          tag_dout_d = cpu_dout;
          valid_d    = 1'b1;
          mem_addr_d = addr;
          mem_we_d   = we;
          mem_din_d  = cpu_dout;
          mem_req_d  = 1'b1;
          ok_d       = 1'b0;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
          tcnt_d     = '0;
`endif
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ok) begin
          if (!mem_we_q) cpu_din_d = mem_dout;
          mem_req_d = 1'b0;
          ws_cnt_d  = '0;
          state_d   = (WS == 0) ? ST_DONE : ST_WS;
        end
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
        // Backend never answered: complete with a bus-float value and flag it
        else if (({1'b0, tcnt_q} + (TW+1)'(1)) == (TW+1)'(TOUT)) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) cpu_din_d = 8'hFF;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      ST_WS: begin
        if (cen2) begin
          if (({1'b0, ws_cnt_q} + 5'd1) == 5'(WS)) state_d = ST_DONE;
          else ws_cnt_d = ws_cnt_q + WSW'(1);
        end
      end
      ST_DONE: begin
        ok_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tag_addr_q <= '0;
      tag_we_q   <= 1'b0;
      tag_dout_q <= '0;
      valid_q    <= 1'b0;
      ok_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      cpu_din_q  <= 8'h00;
      ws_cnt_q   <= '0;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
      tcnt_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tag_addr_q <= tag_addr_d;
      tag_we_q   <= tag_we_d;
      tag_dout_q <= tag_dout_d;
      valid_q    <= valid_d;
      ok_q       <= ok_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      mem_req_q  <= mem_req_d;
      cpu_din_q  <= cpu_din_d;
      ws_cnt_q   <= ws_cnt_d;
`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Bench for jtkcpu_busresp: two instances (WS=0 and WS=3) share the CPU side, each with its own backend.
// Timeout checks are compiled in with JTKCPU_BUSRESP_TIMEOUT_EN.
module tb_jtkcpu_busresp;

  localparam int unsigned TOUT_TB = 16;
  localparam int unsigned WS1     = 3;

  logic        clk = 1'b0;
  logic        rst, cen2, we;
  logic [23:0] addr;
  logic [7:0]  cpu_dout;
  logic        mem_ok   [2];
  logic [7:0]  mem_dout [2];
  logic [7:0]  cpu_din  [2];
  logic        dtack    [2];
  logic [23:0] mem_addr [2];
  logic [7:0]  mem_din  [2];
  logic        mem_we   [2];
  logic        mem_req  [2];
  logic        err      [2];

  always #5 clk = ~clk;

  jtkcpu_busresp #(.WS(0), .TOUT(TOUT_TB)) u_ws0 (
    .rst(rst), .clk(clk), .cen2(cen2), .addr(addr), .cpu_dout(cpu_dout), .we(we),
    .cpu_din(cpu_din[0]), .dtack(dtack[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_we(mem_we[0]), .mem_req(mem_req[0]), .mem_ok(mem_ok[0]), .mem_dout(mem_dout[0]),
    .err(err[0]));

  jtkcpu_busresp #(.WS(WS1), .TOUT(TOUT_TB)) u_ws3 (
    .rst(rst), .clk(clk), .cen2(cen2), .addr(addr), .cpu_dout(cpu_dout), .we(we),
    .cpu_din(cpu_din[1]), .dtack(dtack[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_we(mem_we[1]), .mem_req(mem_req[1]), .mem_ok(mem_ok[1]), .mem_dout(mem_dout[1]),
    .err(err[1]));

  typedef struct {
    logic [23:0] a;
    logic        w;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          exp_req;
    logic [7:0]  exp_din;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fix_delay, force_dout;
  bit stall, stray_en;

  // Expected-behaviour model per instance: last served access, pending request, completion cycle
  bit          m_valid [2];
  logic [23:0] s_addr  [2];
  logic        s_we    [2];
  logic [7:0]  s_dout  [2];
  bit          m_ok    [2];
  bit          busy    [2];
  bit          pend    [2];
  bit          idle_end[2];
  int          delay   [2];
  int          issue_cyc[2];
  int          done_at [2];
  int          cen_left[2];
  logic [7:0]  exp_din [2];
  bit          err_exp [2];
  int          req_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : int'(WS1);
  endfunction

  function automatic logic [7:0] rdata(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic bit live_match(input int i);
    return m_valid[i] && (addr == s_addr[i]) && (we == s_we[i]) && (cpu_dout == s_dout[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_ok[i] = 0; busy[i] = 0; pend[i] = 0; idle_end[i] = 1;
      done_at[i] = -1; cen_left[i] = 0; exp_din[i] = 8'h00; err_exp[i] = 0;
      mem_ok[i] = 1'b0; mem_dout[i] = 8'h00;
    end
  endtask

  task automatic step();
    logic [7:0] d;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (done_at[i] == cyc) begin m_ok[i] = 1; busy[i] = 0; done_at[i] = -1; end
      if (idle_end[i] && !live_match(i)) begin
        s_addr[i] = addr; s_we[i] = we; s_dout[i] = cpu_dout; m_valid[i] = 1;
        m_ok[i] = 0; busy[i] = 1; pend[i] = 1; issue_cyc[i] = cyc; req_cnt[i]++;
        delay[i] = (fix_delay >= 0) ? fix_delay : int'($urandom_range(3));
      end
      chk("mem_req", 32'(mem_req[i]), 32'(pend[i]));
      if (pend[i]) begin
        chk("mem_addr", 32'(mem_addr[i]), 32'(s_addr[i]));
        chk("mem_we", 32'(mem_we[i]), 32'(s_we[i]));
        chk("mem_din", 32'(mem_din[i]), 32'(s_dout[i]));
      end
      chk("dtack", 32'(dtack[i]), 32'(m_ok[i] && live_match(i)));
      chk("cpu_din", 32'(cpu_din[i]), 32'(exp_din[i]));
      chk("err", 32'(err[i]), 32'(err_exp[i]));
    end
    cen2 = cyc[0];
    for (int i = 0; i < 2; i++) begin
      if (cen_left[i] > 0 && cen2) begin
        cen_left[i]--;
        if (cen_left[i] == 0) done_at[i] = cyc + 2;
      end
      mem_ok[i] = 1'b0;
      mem_dout[i] = 8'($urandom);
      if (pend[i]) begin
        if (stall) begin
          if (cyc - issue_cyc[i] == int'(TOUT_TB) - 1) begin
            pend[i] = 0; err_exp[i] = 1; done_at[i] = cyc + 2;
            if (!s_we[i]) exp_din[i] = 8'hFF;
          end
        end else if (delay[i] == 0) begin
          d = (force_dout >= 0) ? 8'(force_dout) : rdata(s_addr[i]);
          mem_ok[i] = 1'b1; mem_dout[i] = d; pend[i] = 0;
          if (!s_we[i]) exp_din[i] = d;
          if (ws_of(i) == 0) done_at[i] = cyc + 2;
          else cen_left[i] = ws_of(i);
        end else begin
          delay[i]--;
        end
      end else if (stray_en && $urandom_range(3) == 0) begin
        mem_ok[i] = 1'b1;
      end
      idle_end[i] = !busy[i];
    end
  endtask

  task automatic drive_access(input logic [23:0] a, input logic w, input logic [7:0] d);
    addr = a; we = w; cpu_dout = d;
    #1;
    for (int i = 0; i < 2; i++)
      chk("dtack_now", 32'(dtack[i]), 32'(m_ok[i] && live_match(i)));
  endtask

  task automatic wait_done();
    int n = 0;
    bit fin = 0;
    while (!fin && n < 300) begin
      step();
      n++;
      fin = (n >= 3) && m_ok[0] && live_match(0) && m_ok[1] && live_match(1);
    end
    chk("wait_done_timeout", 32'(fin), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_mem_req", 32'(mem_req[i]), 32'(0));
        chk("rst_dtack", 32'(dtack[i]), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr[i]), 32'(0));
        chk("rst_mem_din", 32'(mem_din[i]), 32'(0));
        chk("rst_mem_we", 32'(mem_we[i]), 32'(0));
        chk("rst_cpu_din", 32'(cpu_din[i]), 32'(0));
        chk("rst_err", 32'(err[i]), 32'(0));
      end
      @(negedge clk);
    end
    model_reset();
    rst = 1'b0;
  endtask

  vec_t vec [9];

  initial begin
    int r0 [2];
    logic [23:0] ra;
    vec[0] = '{24'h00FFFE, 1'b0, 8'h00, 8'h12, 1, 8'h12};
    vec[1] = '{24'h001000, 1'b1, 8'hA5, 8'h77, 1, 8'h12};
    vec[2] = '{24'h002000, 1'b0, 8'h00, 8'h34, 1, 8'h34};
    vec[3] = '{24'h002001, 1'b0, 8'h00, 8'h56, 1, 8'h56};
    vec[4] = '{24'h002001, 1'b0, 8'h00, 8'hEE, 0, 8'h56};
    vec[5] = '{24'h001000, 1'b1, 8'hA5, 8'h11, 1, 8'h56};
    vec[6] = '{24'h001000, 1'b1, 8'hA5, 8'h22, 0, 8'h56};
    vec[7] = '{24'h001000, 1'b1, 8'h5A, 8'h33, 1, 8'h56};
    vec[8] = '{24'h001000, 1'b0, 8'h5A, 8'h9C, 1, 8'h9C};
    rst = 1'b1; cen2 = 1'b0; addr = '0; we = 1'b0; cpu_dout = '0;
    fix_delay = 1; force_dout = -1; stall = 0; stray_en = 0;
    for (int i = 0; i < 2; i++) req_cnt[i] = 0;
    model_reset();
    do_reset();

    // Directed table: read, write, address step, latch hit, data/direction changes
    for (int k = 0; k < 9; k++) begin
      force_dout = int'(vec[k].rd);
      for (int i = 0; i < 2; i++) r0[i] = req_cnt[i];
      drive_access(vec[k].a, vec[k].w, vec[k].d);
      wait_done();
      for (int i = 0; i < 2; i++) begin
        chk("vec_cpu_din", 32'(cpu_din[i]), 32'(vec[k].exp_din));
        chk("vec_req_count", 32'(req_cnt[i] - r0[i]), 32'(vec[k].exp_req));
      end
    end

    // Randomized accesses with repeats, stray mem_ok and mid-access changes
    fix_delay = -1; force_dout = -1; stray_en = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(3) != 0) begin
        ra = ($urandom_range(3) == 0) ? 24'($urandom) : (24'h004000 | 24'($urandom_range(7)));
        drive_access(ra, 1'($urandom), 8'($urandom_range(3)));
      end
      if ($urandom_range(4) == 0) begin
        repeat ($urandom_range(3, 1)) step();
        drive_access(24'h004000 | 24'($urandom_range(7)), 1'($urandom), 8'($urandom_range(3)));
      end
      wait_done();
    end
    stray_en = 0;

    // Reset in the middle of a pending request
    fix_delay = 5;
    drive_access(24'h005000, 1'b0, 8'h00);
    step(); step();
    chk("pre_rst_mem_req", 32'(mem_req[0]), 32'(1));
    do_reset();
    for (int i = 0; i < 2; i++) r0[i] = req_cnt[i];
    wait_done();
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_req_count", 32'(req_cnt[i] - r0[i]), 32'(1));
      chk("post_rst_cpu_din", 32'(cpu_din[i]), 32'(rdata(24'h005000)));
    end
    fix_delay = -1;

`ifdef JTKCPU_BUSRESP_TIMEOUT_EN
    // Backend never answers: timeout completes the read with 0xFF and sets sticky err
    stall = 1;
    drive_access(24'h003000, 1'b0, 8'h00);
    wait_done();
    stall = 0;
    for (int i = 0; i < 2; i++) begin
      chk("tout_cpu_din", 32'(cpu_din[i]), 32'(8'hFF));
      chk("tout_err", 32'(err[i]), 32'(1));
      chk("tout_dtack", 32'(dtack[i]), 32'(1));
    end
    drive_access(24'h003001, 1'b0, 8'h00);
    wait_done();
    for (int i = 0; i < 2; i++) chk("err_sticky", 32'(err[i]), 32'(1));
    do_reset();
    wait_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
